// File: rtl/regbank_write_arbiter.sv
// Two-requester writeback arbiter for a register bank: ALU and MEM each own a one-entry
// holding buffer that competes for a single registered write port, with hazard stall output.
module regbank_write_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              stall,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] dataToWrite
);

  logic              alu_full_q, mem_full_q;
  logic [ADDR_W-1:0] alu_rd_q, mem_rd_q;
  logic [DATA_W-1:0] alu_data_q, mem_data_q;
  // ptr_q: 1 selects MEM on the next contested grant; age_q: 1 means MEM entry is older
  logic              ptr_q, age_q;

  logic grant_alu, grant_mem;
  logic alu_fire, mem_fire;
  logic alu_full_d, mem_full_d, age_d;

  assign alu_ready = !alu_full_q;
  assign mem_ready = !mem_full_q;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_full_q && mem_full_q) begin
      // Same destination must commit in arrival order, otherwise alternate
      grant_mem = (alu_rd_q == mem_rd_q) ? age_q : ptr_q;
      grant_alu = !grant_mem;
    end else begin
      grant_alu = alu_full_q;
      grant_mem = mem_full_q;
    end

    alu_fire   = alu_valid && !alu_full_q;
    mem_fire   = mem_valid && !mem_full_q;
    alu_full_d = alu_fire || (alu_full_q && !grant_alu);
    mem_full_d = mem_fire || (mem_full_q && !grant_mem);

    age_d = age_q;
    if (alu_fire && mem_fire) begin
      age_d = 1'b0;
    end else if (alu_fire) begin
      age_d = mem_full_d;
    end else if (mem_fire) begin
      age_d = !alu_full_d;
    end
  end

  always_comb begin
    stall = 1'b0;
    if (alu_full_q && (rs == alu_rd_q || rt == alu_rd_q)) begin
      stall = 1'b1;
    end
    if (mem_full_q && (rs == mem_rd_q || rt == mem_rd_q)) begin
      stall = 1'b1;
    end
    if (RegWrite && (rs == rd || rt == rd)) begin
      stall = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_full_q  <= 1'b0;
      mem_full_q  <= 1'b0;
      alu_rd_q    <= '0;
      mem_rd_q    <= '0;
      alu_data_q  <= '0;
      mem_data_q  <= '0;
      ptr_q       <= 1'b0;
      age_q       <= 1'b0;
      RegWrite    <= 1'b0;
      rd          <= '0;
      dataToWrite <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      mem_full_q <= mem_full_d;
      age_q      <= age_d;
      if (alu_fire) begin
        alu_rd_q   <= alu_rd;
        alu_data_q <= alu_data;
      end
      if (mem_fire) begin
        mem_rd_q   <= mem_rd;
        mem_data_q <= mem_data;
      end
      if (alu_full_q && mem_full_q) begin
        ptr_q <= grant_alu;
      end
      RegWrite <= grant_alu || grant_mem;
      if (grant_alu) begin
        rd          <= alu_rd_q;
        dataToWrite <= alu_data_q;
      end else if (grant_mem) begin
        rd          <= mem_rd_q;
        dataToWrite <= mem_data_q;
      end
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: one task per scenario, inline comparisons.
module tb_regbank_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [2:0]  alu_rd, mem_rd, rs, rt;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, stall, RegWrite;
  logic [2:0]  rd;
  logic [15:0] dataToWrite;

  int tests = 0;
  int fails = 0;

  regbank_write_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rs(rs), .rt(rt), .stall(stall),
    .RegWrite(RegWrite), .rd(rd), .dataToWrite(dataToWrite)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rs = 3'd0;
    rt = 3'd0;
    do_reset();
    tests++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    tests++; if (rd !== 3'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", rd); end
    tests++; if (dataToWrite !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", dataToWrite); end
    tests++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got alu=%b mem=%b want 1 1", alu_ready, mem_ready);
    end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_single_write();
    alu_valid = 1'b1; alu_rd = 3'd5; alu_data = 16'h1234;
    tick();
    alu_valid = 1'b0;
    tests++; if (alu_ready !== 1'b0 || RegWrite !== 1'b0) begin
      fails++; $display("FAIL single_cyc1 got ready=%b we=%b want 0 0", alu_ready, RegWrite);
    end
    tick();
    tests++; if (RegWrite !== 1'b1 || rd !== 3'd5 || dataToWrite !== 16'h1234) begin
      fails++; $display("FAIL single_write got we=%b rd=%0d d=%h want 1 5 1234", RegWrite, rd, dataToWrite);
    end
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL single_ready2 got %b want 1", alu_ready); end
    tick();
    tests++; if (RegWrite !== 1'b0 || rd !== 3'd5 || dataToWrite !== 16'h1234) begin
      fails++; $display("FAIL single_hold got we=%b rd=%0d d=%h want 0 5 1234", RegWrite, rd, dataToWrite);
    end
  endtask

  // Both requesters fill at once; expect (first, second) destination order
  task automatic contest(input logic [2:0] ard, input logic [2:0] mrd,
                         input logic [15:0] ad, input logic [15:0] md,
                         input logic [2:0] first_rd, input logic [15:0] first_d,
                         input logic [2:0] second_rd, input logic [15:0] second_d);
    alu_valid = 1'b1; alu_rd = ard; alu_data = ad;
    mem_valid = 1'b1; mem_rd = mrd; mem_data = md;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tests++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      fails++; $display("FAIL contest_full got alu=%b mem=%b want 0 0", alu_ready, mem_ready);
    end
    tick();
    tests++; if (RegWrite !== 1'b1 || rd !== first_rd || dataToWrite !== first_d) begin
      fails++; $display("FAIL contest_first got we=%b rd=%0d d=%h want 1 %0d %h",
                        RegWrite, rd, dataToWrite, first_rd, first_d);
    end
    tick();
    tests++; if (RegWrite !== 1'b1 || rd !== second_rd || dataToWrite !== second_d) begin
      fails++; $display("FAIL contest_second got we=%b rd=%0d d=%h want 1 %0d %h",
                        RegWrite, rd, dataToWrite, second_rd, second_d);
    end
    tick();
    tests++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL contest_idle got %b want 0", RegWrite); end
  endtask

  task automatic test_round_robin();
    do_reset();
    contest(3'd2, 3'd3, 16'h0202, 16'h0303, 3'd2, 16'h0202, 3'd3, 16'h0303);
    contest(3'd2, 3'd3, 16'h0222, 16'h0333, 3'd3, 16'h0333, 3'd2, 16'h0222);
  endtask

  task automatic test_same_rd_age();
    do_reset();
    // Leaves the pointer on MEM, so the same-rd pair is decided by age alone
    contest(3'd0, 3'd7, 16'h0A0A, 16'h0707, 3'd0, 16'h0A0A, 3'd7, 16'h0707);
    contest(3'd1, 3'd1, 16'h1111, 16'h2222, 3'd1, 16'h1111, 3'd1, 16'h2222);
  endtask

  task automatic test_mem_then_alu();
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h5555;
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 3'd4; mem_data = 16'hAAAA;
    tick();
    mem_valid = 1'b0;
    tests++; if (RegWrite !== 1'b1 || rd !== 3'd1 || dataToWrite !== 16'h5555) begin
      fails++; $display("FAIL order_pending got we=%b rd=%0d d=%h want 1 1 5555", RegWrite, rd, dataToWrite);
    end
    alu_valid = 1'b1; alu_rd = 3'd4; alu_data = 16'hBBBB;
    tick();
    alu_valid = 1'b0;
    tests++; if (RegWrite !== 1'b1 || rd !== 3'd4 || dataToWrite !== 16'hAAAA) begin
      fails++; $display("FAIL order_mem got we=%b rd=%0d d=%h want 1 4 aaaa", RegWrite, rd, dataToWrite);
    end
    tick();
    tests++; if (RegWrite !== 1'b1 || rd !== 3'd4 || dataToWrite !== 16'hBBBB) begin
      fails++; $display("FAIL order_alu got we=%b rd=%0d d=%h want 1 4 bbbb", RegWrite, rd, dataToWrite);
    end
    tick();
    tests++; if (RegWrite !== 1'b0 || dataToWrite !== 16'hBBBB) begin
      fails++; $display("FAIL order_final got we=%b d=%h want 0 bbbb", RegWrite, dataToWrite);
    end
  endtask

  task automatic test_hazard();
    rs = 3'd6; rt = 3'd2;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hazard_idle got %b want 0", stall); end
    mem_valid = 1'b1; mem_rd = 3'd6; mem_data = 16'h6666;
    tick();
    mem_valid = 1'b0;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hazard_buffer got %b want 1", stall); end
    tick();
    tests++; if (stall !== 1'b1 || RegWrite !== 1'b1 || rd !== 3'd6) begin
      fails++; $display("FAIL hazard_write got stall=%b we=%b rd=%0d want 1 1 6", stall, RegWrite, rd);
    end
    tick();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hazard_clear got %b want 0", stall); end
    // Register 0 is hazard-checked like any other, here via rt
    rs = 3'd3; rt = 3'd0;
    alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'h0F0F;
    tick();
    alu_valid = 1'b0;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hazard_r0_buf got %b want 1", stall); end
    tick();
    tests++; if (stall !== 1'b1 || RegWrite !== 1'b1 || rd !== 3'd0 || dataToWrite !== 16'h0F0F) begin
      fails++; $display("FAIL hazard_r0_write got stall=%b we=%b rd=%0d d=%h want 1 1 0 0f0f",
                        stall, RegWrite, rd, dataToWrite);
    end
    tick();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hazard_r0_clear got %b want 0", stall); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int wrote = 0;
    logic hs;
    logic [15:0] exp_d;
    rs = 3'd0; rt = 3'd0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 10);
      alu_rd    = 3'd5;
      alu_data  = 16'hC000 + 16'(sent);
      hs = alu_valid && alu_ready;
      tick();
      if (hs) sent++;
      if (RegWrite === 1'b1) begin
        exp_d = 16'hC000 + 16'(wrote);
        tests++; if (rd !== 3'd5 || dataToWrite !== exp_d) begin
          fails++; $display("FAIL b2b_write%0d got rd=%0d d=%h want 5 %h", wrote, rd, dataToWrite, exp_d);
        end
        wrote++;
      end
    end
    alu_valid = 1'b0;
    tests++; if (sent != 5) begin fails++; $display("FAIL b2b_accepted got %0d want 5", sent); end
    tests++; if (wrote != 5) begin fails++; $display("FAIL b2b_writes got %0d want 5", wrote); end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    do_reset();
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h1001;
    mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 16'h2002;
    tick();
    mem_valid = 1'b0;
    alu_data  = 16'h1003;
    tick();
    tests++; if (RegWrite !== 1'b1 || mem_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_pre got we=%b mem_ready=%b want 1 0", RegWrite, mem_ready);
    end
    // Reset lands on an edge with a pending grant and an ALU handshake
    reset = 1'b1;
    tick();
    reset = 1'b0;
    alu_valid = 1'b0;
    tests++; if (RegWrite !== 1'b0 || rd !== 3'd0 || dataToWrite !== 16'h0) begin
      fails++; $display("FAIL rstmid_out got we=%b rd=%0d d=%h want 0 0 0000", RegWrite, rd, dataToWrite);
    end
    tests++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_ready got alu=%b mem=%b want 1 1", alu_ready, mem_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (RegWrite === 1'b1) late++;
    end
    tests++; if (late != 0) begin fails++; $display("FAIL rstmid_ghost got %0d writes want 0", late); end
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rs = '0; rt = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_same_rd_age();
    test_mem_then_alu();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, data word width; SHALL match the register bank data width.
REQ-002 Parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 clock  input  1  single clock; all state SHALL update on the posedge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 alu_valid  input  1  ALU writeback request present.
REQ-006 alu_rd  input  ADDR_W  ALU destination register.
REQ-007 alu_data  input  DATA_W  ALU result.
REQ-008 alu_ready  output  1  ALU holding buffer empty; transfer occurs when alu_valid && alu_ready at posedge.
REQ-009 mem_valid, mem_rd, mem_data, mem_ready  same widths/meaning for the load-writeback requester.
REQ-010 rs, rt  input  ADDR_W  source registers of the instruction in decode.
REQ-011 stall  output  1  rs or rt targets a write not yet committed.
REQ-012 RegWrite  output  1  registered write strobe to the register bank.
REQ-013 rd  output  ADDR_W  registered write address.
REQ-014 dataToWrite  output  DATA_W  registered write data.

Function
REQ-015 Each requester SHALL own a one-entry holding buffer (full flag, rd, data); ready SHALL equal !full, purely from state.
REQ-016 On handshake at posedge N the buffer SHALL capture rd/data and set full.
REQ-017 At each posedge with at least one buffer full, the arbiter SHALL grant exactly one buffer, clear its full flag, and load RegWrite=1, rd, dataToWrite from it.
REQ-018 At a posedge with no buffer full, RegWrite SHALL load 0; rd and dataToWrite SHALL hold their previous values.
REQ-019 Latency: handshake at posedge N -> RegWrite high for the cycle after posedge N+1 (if granted), held stable for the whole cycle so the bank's negedge write sees it.
REQ-020 A granted buffer SHALL NOT accept new data at the same edge it is granted (ready was 0); refill is possible from the next edge, giving one write per requester per two cycles max.
REQ-021 Arbitration, both full, different rd: round-robin; a 1-bit pointer SHALL select the requester not granted most recently; pointer after reset = ALU.
REQ-022 Both full, same rd: the older entry SHALL be granted first regardless of pointer; a 1-bit age flag SHALL record which buffer filled first; if both filled at the same edge, ALU is older.
REQ-023 Pointer SHALL update only on a contested grant (both full); an uncontested grant SHALL leave it unchanged.
REQ-024 stall SHALL be combinational: 1 when rs or rt equals the rd of any full buffer, or equals output rd while RegWrite=1; else 0.
REQ-025 Register 0 SHALL receive no special treatment (writable, hazard-checked).
REQ-026 No request SHALL ever be dropped or duplicated; each accepted entry SHALL produce exactly one RegWrite cycle.

Reset
REQ-027 While reset=1 at posedge: both full flags, age flag, RegWrite SHALL clear to 0; pointer SHALL select ALU; rd and dataToWrite SHALL clear to 0.
REQ-028 Reset SHALL dominate a simultaneous handshake or grant; buffered entries are discarded and ready=1 from the cycle after reset.
REQ-029 Reset asserted while RegWrite=1 SHALL drop RegWrite to 0 at that edge.

Verification
REQ-030 Single ALU write: alu_valid=1, alu_rd=5, alu_data=16'h1234 at posedge 1 -> alu_ready=0 in cycle 1; RegWrite=1, rd=5, dataToWrite=16'h1234 in cycle 2; RegWrite=0 in cycle 3.
REQ-031 Contest, different rd: both accepted same edge (ALU rd=2, MEM rd=3) after reset -> ALU written first, MEM next cycle; repeat -> MEM first (pointer rotated).
REQ-032 Same-rd ordering: MEM rd=4 data=16'hAAAA accepted at edge 1 while a write is pending, ALU rd=4 data=16'hBBBB at edge 2 -> MEM write precedes ALU write; final value 16'hBBBB.
REQ-033 Hazard: MEM buffer holding rd=6, rs=6 -> stall=1; stall stays 1 through the RegWrite cycle for rd=6 and returns to 0 the cycle after.
REQ-034 Back-to-back throughput: alu_valid held high for 10 cycles, distinct data -> exactly 5 accepted, 5 RegWrite pulses in order, no loss.
REQ-035 Reset mid-operation: both buffers full and RegWrite=1, assert reset for one edge -> RegWrite=0, both ready=1 next cycle, no later write of the discarded entries.
